// File: rtl/alu_seq_pkg.sv
// Shared encodings and instruction field layout for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int INSTR_W = 24;
    localparam int REG_AW  = 2;
    localparam int OPC_W   = 8;

    localparam int OPC_MSB  = 23;
    localparam int OPC_LSB  = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 8;
    localparam int DST_MSB  = 7;
    localparam int DST_LSB  = 6;
    localparam int SRCA_MSB = 5;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 3;
    localparam int SRCB_LSB = 2;
    localparam int USE_IMM_BIT = 1;
    localparam int WB_EN_BIT   = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    function automatic logic [INSTR_W-1:0] mk_instr(
        input logic [7:0]        opc,
        input logic [7:0]        imm,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] srca,
        input logic [REG_AW-1:0] srcb,
        input logic              use_imm,
        input logic              wb_en
    );
        return {opc, imm, dst, srca, srcb, use_imm, wb_en};
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Instruction, ALU, preload and debug signals between the sequencer and its
// environment.
interface alu_operand_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic [INSTR_W-1:0] INSTR;
    logic [DATA_W-1:0]  OP_A;
    logic [DATA_W-1:0]  OP_B;
    logic [OPC_W-1:0]   OPCODE;
    logic [DATA_W-1:0]  ALU_OUT;
    logic               CARRY;
    logic               EXT_WE;
    logic [REG_AW-1:0]  EXT_ADDR;
    logic [DATA_W-1:0]  EXT_WDATA;
    logic [REG_AW-1:0]  DBG_ADDR;
    logic [DATA_W-1:0]  DBG_DATA;
    logic               CARRY_FLAG;
    logic               DONE;

    modport slave (
        input  INSTR_VALID, INSTR, ALU_OUT, CARRY,
        input  EXT_WE, EXT_ADDR, EXT_WDATA, DBG_ADDR,
        output INSTR_READY, OP_A, OP_B, OPCODE,
        output DBG_DATA, CARRY_FLAG, DONE
    );

    modport master (
        output INSTR_VALID, INSTR, ALU_OUT, CARRY,
        output EXT_WE, EXT_ADDR, EXT_WDATA, DBG_ADDR,
        input  INSTR_READY, OP_A, OP_B, OPCODE,
        input  DBG_DATA, CARRY_FLAG, DONE
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// Small register file: async clear, one write port, three combinational
// read ports (operand A, operand B, debug).
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [REG_AW-1:0] raddr_d_i,
    output logic [DATA_W-1:0] rdata_d_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign rdata_d_o = regs_q[raddr_d_i];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage for an 8-bit ALU: reads operands, waits for the ALU result and
// writes it back. One instruction in flight, so no hazards exist.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NREGS       = 4,
    parameter int ALU_LATENCY = 1
) (
    input logic CLK,
    input logic RESET,
    alu_operand_sequencer_if.slave bus
);

    localparam int CW =
        (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [REG_AW-1:0]  dst_q;
    logic               wb_q;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [OPC_W-1:0]   opc_q;
    logic               cf_q;
    logic               done_q;

    logic [OPC_W-1:0]   f_opc;
    logic [7:0]         f_imm;
    logic [REG_AW-1:0]  f_dst;
    logic [REG_AW-1:0]  f_sa;
    logic [REG_AW-1:0]  f_sb;
    logic               f_use;
    logic               f_wb;

    logic [DATA_W-1:0]  rd_a;
    logic [DATA_W-1:0]  rd_b;
    logic               idle;
    logic               fire;
    logic               rf_we;
    logic [REG_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;

    assign f_opc = bus.INSTR[OPC_MSB:OPC_LSB];
    assign f_imm = bus.INSTR[IMM_MSB:IMM_LSB];
    assign f_dst = bus.INSTR[DST_MSB:DST_LSB];
    assign f_sa  = bus.INSTR[SRCA_MSB:SRCA_LSB];
    assign f_sb  = bus.INSTR[SRCB_MSB:SRCB_LSB];
    assign f_use = bus.INSTR[USE_IMM_BIT];
    assign f_wb  = bus.INSTR[WB_EN_BIT];

    assign idle = (state_q == S_IDLE);
    assign fire = (state_q == S_WAIT) && (cnt_q == '0);

    // External preload only lands in IDLE, so it never races writeback.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.EXT_ADDR;
        rf_wdata = bus.EXT_WDATA;
        unique case (1'b1)
            fire: begin
                rf_we    = wb_q;
                rf_waddr = dst_q;
                rf_wdata = bus.ALU_OUT;
            end
            idle:    rf_we = bus.EXT_WE;
            default: ;
        endcase
    end

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (f_sa),
        .rdata_a_o (rd_a),
        .raddr_b_i (f_sb),
        .rdata_b_o (rd_b),
        .raddr_d_i (bus.DBG_ADDR),
        .rdata_d_o (bus.DBG_DATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            wb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            cf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.INSTR_VALID) begin
                        opa_q   <= rd_a;
                        opb_q   <= f_use ? f_imm : rd_b;
                        opc_q   <= f_opc;
                        dst_q   <= f_dst;
                        wb_q    <= f_wb;
                        cnt_q   <= CW'(ALU_LATENCY);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cf_q    <= bus.CARRY;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.INSTR_READY = idle;
    assign bus.OP_A        = opa_q;
    assign bus.OP_B        = opb_q;
    assign bus.OPCODE      = opc_q;
    assign bus.CARRY_FLAG  = cf_q;
    assign bus.DONE        = done_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: three sequencers (ALU latency 0, 1, 3) share one stimulus
// stream, each fed by its own adder model.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               valid = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic               ext_we = 1'b0;
    logic [1:0]         ext_addr = '0;
    logic [7:0]         ext_wdata = '0;
    logic [1:0]         dbg_addr = '0;

    int n_chk = 0;
    int n_fail = 0;

    alu_operand_sequencer_if #(.DATA_W(8)) if0 ();
    alu_operand_sequencer_if #(.DATA_W(8)) if1 ();
    alu_operand_sequencer_if #(.DATA_W(8)) if3 ();

    assign if0.INSTR_VALID = valid;
    assign if0.INSTR       = instr;
    assign if0.EXT_WE      = ext_we;
    assign if0.EXT_ADDR    = ext_addr;
    assign if0.EXT_WDATA   = ext_wdata;
    assign if0.DBG_ADDR    = dbg_addr;
    assign if1.INSTR_VALID = valid;
    assign if1.INSTR       = instr;
    assign if1.EXT_WE      = ext_we;
    assign if1.EXT_ADDR    = ext_addr;
    assign if1.EXT_WDATA   = ext_wdata;
    assign if1.DBG_ADDR    = dbg_addr;
    assign if3.INSTR_VALID = valid;
    assign if3.INSTR       = instr;
    assign if3.EXT_WE      = ext_we;
    assign if3.EXT_ADDR    = ext_addr;
    assign if3.EXT_WDATA   = ext_wdata;
    assign if3.DBG_ADDR    = dbg_addr;

    // Adder models: sum of operands delayed by 0, 1 and 3 edges.
    logic [8:0] s1;
    logic [8:0] p3 [3];
    assign {if0.CARRY, if0.ALU_OUT} = {1'b0, if0.OP_A} + {1'b0, if0.OP_B};
    always @(posedge clk) s1 <= {1'b0, if1.OP_A} + {1'b0, if1.OP_B};
    assign {if1.CARRY, if1.ALU_OUT} = s1;
    always @(posedge clk) begin
        p3[0] <= {1'b0, if3.OP_A} + {1'b0, if3.OP_B};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {if3.CARRY, if3.ALU_OUT} = p3[2];

    alu_operand_sequencer #(.DATA_W(8), .NREGS(4), .ALU_LATENCY(0)) dut0 (
        .CLK(clk), .RESET(rst_n), .bus(if0));
    alu_operand_sequencer #(.DATA_W(8), .NREGS(4), .ALU_LATENCY(1)) dut1 (
        .CLK(clk), .RESET(rst_n), .bus(if1));
    alu_operand_sequencer #(.DATA_W(8), .NREGS(4), .ALU_LATENCY(3)) dut3 (
        .CLK(clk), .RESET(rst_n), .bus(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_rf [4];
    int dn0, dn1, dn3;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_opa", if1.OP_A, 0);
        chk("rst_opb", if1.OP_B, 0);
        chk("rst_opc", if1.OPCODE, 0);
        chk("rst_cf", if1.CARRY_FLAG, 0);
        chk("rst_done", if1.DONE, 0);
        chk("rst_r0", if1.DBG_DATA, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", if1.INSTR_READY, 1);

        // Test 1: preload and add
        ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 8'h12;
        tick();
        ext_addr = 2'd1; ext_wdata = 8'h34;
        tick();
        ext_we = 1'b0;
        #1 chk("t1_r0", if1.DBG_DATA, 8'h12);
        instr = mk_instr(8'h01, 8'h00, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1);
        valid = 1'b1;
        dbg_addr = 2'd2;
        tick();
        valid = 1'b0;
        chk("t1_opc", if1.OPCODE, 8'h01);
        chk("t1_opa", if1.OP_A, 8'h12);
        chk("t1_opb", if1.OP_B, 8'h34);
        chk("t1_ready0", if1.INSTR_READY, 0);
        chk("t1_done0", if1.DONE, 0);
        tick();
        chk("t1_done1", if1.DONE, 0);
        tick();
        chk("t1_done2", if1.DONE, 1);
        chk("t1_ready2", if1.INSTR_READY, 1);
        chk("t1_r2", if1.DBG_DATA, 8'h46);
        chk("t1_cf", if1.CARRY_FLAG, 0);
        tick();
        chk("t1_done3", if1.DONE, 0);

        // Test 2: immediate with carry out
        ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 8'hF0;
        tick();
        ext_we = 1'b0;
        instr = mk_instr(8'h02, 8'h20, 2'd3, 2'd0, 2'd0, 1'b1, 1'b1);
        valid = 1'b1;
        dbg_addr = 2'd3;
        tick();
        valid = 1'b0;
        chk("t2_opa", if1.OP_A, 8'hF0);
        chk("t2_opb", if1.OP_B, 8'h20);
        tick();
        tick();
        chk("t2_done", if1.DONE, 1);
        chk("t2_r3", if1.DBG_DATA, 8'h10);
        chk("t2_cf", if1.CARRY_FLAG, 1);
        tick();

        // Test 3: VALID held high, r2 accumulates r1
        instr = mk_instr(8'h03, 8'h00, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1);
        valid = 1'b1;
        dbg_addr = 2'd2;
        dn1 = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("t3_ready", if1.INSTR_READY, (i % 3 == 0));
            chk("t3_done", if1.DONE, (i % 3 == 0));
            if (if1.DONE) dn1++;
        end
        valid = 1'b0;
        chk("t3_ndone", dn1, 3);
        chk("t3_r2", if1.DBG_DATA, 8'hE2);
        chk("t3_cf", if1.CARRY_FLAG, 0);

        // Test 4: EXT in accept cycle lands, EXT during WAIT ignored
        instr = mk_instr(8'h04, 8'h05, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1);
        valid = 1'b1;
        ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 8'h55;
        dbg_addr = 2'd0;
        tick();
        valid = 1'b0;
        chk("t4_opa_old", if1.OP_A, 8'hF0);
        chk("t4_r0_new", if1.DBG_DATA, 8'h55);
        ext_addr = 2'd2; ext_wdata = 8'hAA;
        dbg_addr = 2'd2;
        tick();
        ext_we = 1'b0;
        chk("t4_r2_wait", if1.DBG_DATA, 8'hE2);
        tick();
        chk("t4_done", if1.DONE, 1);
        chk("t4_r2", if1.DBG_DATA, 8'hF5);
        chk("t4_cf", if1.CARRY_FLAG, 0);
        tick();

        // Test 5: wb_en=0 with overflow
        ext_we = 1'b1; ext_addr = 2'd1; ext_wdata = 8'hF0;
        tick();
        ext_we = 1'b0;
        instr = mk_instr(8'h05, 8'h00, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("t5_done", if1.DONE, 1);
        chk("t5_cf", if1.CARRY_FLAG, 1);
        exp_rf[0] = 8'h55;
        exp_rf[1] = 8'hF0;
        exp_rf[2] = 8'hF5;
        exp_rf[3] = 8'h10;
        for (int r = 0; r < 4; r++) begin
            dbg_addr = r[1:0];
            #1 chk("t5_rf", if1.DBG_DATA, exp_rf[r]);
        end
        tick();

        // Test 6: reset in WAIT discards the instruction
        instr = mk_instr(8'h06, 8'h00, 2'd3, 2'd1, 2'd1, 1'b0, 1'b1);
        valid = 1'b1;
        dbg_addr = 2'd3;
        tick();
        valid = 1'b0;
        chk("t6_ready", if1.INSTR_READY, 0);
        chk("t6_opa", if1.OP_A, 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_opa0", if1.OP_A, 0);
        chk("t6_opb0", if1.OP_B, 0);
        chk("t6_opc0", if1.OPCODE, 0);
        chk("t6_cf0", if1.CARRY_FLAG, 0);
        chk("t6_r3", if1.DBG_DATA, 0);
        tick();
        chk("t6_done_a", if1.DONE, 0);
        tick();
        chk("t6_done_b", if1.DONE, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_ready1", if1.INSTR_READY, 1);
        chk("t6_r3_nowb", if1.DBG_DATA, 0);

        // Test 7: latency 0/1/3 side by side after reset
        ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 8'h12;
        tick();
        ext_addr = 2'd1; ext_wdata = 8'h34;
        tick();
        ext_we = 1'b0;
        instr = mk_instr(8'h01, 8'h00, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1);
        valid = 1'b1;
        dbg_addr = 2'd2;
        tick();
        valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("t7_done_l0", if0.DONE, (j == 1));
            chk("t7_done_l1", if1.DONE, (j == 2));
            chk("t7_done_l3", if3.DONE, (j == 4));
        end
        chk("t7_r2_l0", if0.DBG_DATA, 8'h46);
        chk("t7_r2_l1", if1.DBG_DATA, 8'h46);
        chk("t7_r2_l3", if3.DBG_DATA, 8'h46);
        chk("t7_opc_l3", if3.OPCODE, 8'h01);
        chk("t7_cf_l3", if3.CARRY_FLAG, 0);

        valid = 1'b1;
        dn0 = 0; dn1 = 0; dn3 = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t7_rdy_l0", if0.INSTR_READY, (i % 2 == 0));
            chk("t7_rdy_l1", if1.INSTR_READY, (i % 3 == 0));
            chk("t7_rdy_l3", if3.INSTR_READY, (i % 5 == 0));
            if (if0.DONE) dn0++;
            if (if1.DONE) dn1++;
            if (if3.DONE) dn3++;
        end
        valid = 1'b0;
        chk("t7_n_l0", dn0, 6);
        chk("t7_n_l1", dn1, 4);
        chk("t7_n_l3", dn3, 2);
        for (int i = 0; i < 6; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream issue stage for alu_8_bit.
- Accepts 24-bit instructions over a valid/ready handshake and reads operands from a 4-entry x 8-bit register file.
- Drives OP_A, OP_B and OPCODE into the ALU, waits ALU_LATENCY cycles, then writes ALU_OUT and CARRY back to the register file and carry flag.
- One instruction in flight at a time, so there are no hazards by construction.

Parameters:
- DATA_W, 8: operand/result width; must match the ALU.
- NREGS, 4: register file depth; address width is clog2(NREGS) = 2.
- ALU_LATENCY, 1: number of CLK edges from operands driven to ALU_OUT valid (0 = combinational ALU).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTR_VALID  in  1  instruction present.
- INSTR_READY  out  1  sequencer can accept an instruction.
- INSTR  in  24  fields:
  - [23:16] opcode
  - [15:8] immediate
  - [7:6] dst
  - [5:4] srcA
  - [3:2] srcB
  - [1] use_imm
  - [0] wb_en
- OP_A  out  8  ALU operand A.
- OP_B  out  8  ALU operand B.
- OPCODE  out  8  ALU opcode.
- ALU_OUT  in  8  ALU result.
- CARRY  in  1  ALU carry.
- EXT_WE  in  1  external register write strobe (preload).
- EXT_ADDR  in  2  external write address.
- EXT_WDATA  in  8  external write data.
- DBG_ADDR  in  2  debug read address.
- DBG_DATA  out  8  combinational read of reg[DBG_ADDR].
- CARRY_FLAG  out  1  last captured carry.
- DONE  out  1  one-cycle pulse on writeback.

Behaviour:
- Reset (RESET=0, async) clears the following, and any in-flight instruction is discarded with no writeback:
  - all registers = 0
  - OP_A = OP_B = OPCODE = 0
  - CARRY_FLAG = 0
  - DONE = 0
  - state = IDLE, counter = 0
  - INSTR_READY = 1 from the first cycle after RESET deasserts.
- States are IDLE and WAIT.
- INSTR_READY = (state == IDLE); it is combinational from state only, with no dependency on INSTR_VALID.
- Accept at edge k (IDLE and INSTR_VALID):
  - OP_A <= reg[srcA]
  - OP_B <= use_imm ? immediate : reg[srcB]
  - OPCODE <= opcode
  - latch dst and wb_en; cnt <= ALU_LATENCY; state <= WAIT.
- Operand values are those present before edge k; an EXT write at the same edge k is not visible to the accepted instruction.
- WAIT:
  - If cnt != 0, cnt <= cnt - 1.
  - If cnt == 0 (edge k+ALU_LATENCY+1):
    - CARRY_FLAG <= CARRY
    - if wb_en, reg[dst] <= ALU_OUT
    - DONE <= 1; state <= IDLE.
- DONE is high for exactly one cycle, in the same cycle INSTR_READY returns to 1.
- Throughput is one instruction per ALU_LATENCY+2 cycles; there is no back-to-back acceptance.
- OP_A, OP_B and OPCODE hold stable through WAIT and keep their last value in IDLE.
- EXT_WE is honoured only in IDLE and is silently ignored in WAIT. Consequently writeback and an external write never collide.
- srcA == srcB == dst is legal; operands are read before writeback.
- wb_en = 0: the register file is unchanged, but CARRY_FLAG still updates and DONE still pulses.
- INSTR[0] = wb_en; there is no reserved bit.
- Widths: all data paths are DATA_W bits; there is no sign extension; the immediate is used as-is.

Decomposition:
- Package alu_seq_pkg holds:
  - state encoding (IDLE, WAIT)
  - INSTR field LSB/MSB constants
  - INSTR_W = 24
  - REG_AW = 2
- Sub-module alu_seq_regfile:
  - NREGS x DATA_W flops, async active-low clear
  - three combinational read ports (A, B, DBG)
  - one write port, muxed between EXT and writeback by the sequencer.

Test Plan:
Bench ALU model: {CARRY, ALU_OUT} = OP_A + OP_B registered over ALU_LATENCY edges, for any opcode.
1. Preload via EXT: r0=8'h12, r1=8'h34. Issue opcode 8'h01, dst=2, srcA=0, srcB=1, wb_en=1 -> OPCODE=8'h01, OP_A=8'h12, OP_B=8'h34 the cycle after accept; DONE at accept+2 (ALU_LATENCY=1); r2=8'h46, CARRY_FLAG=0.
2. r0=8'hF0, use_imm=1, immediate=8'h20, dst=3 -> r3=8'h10, CARRY_FLAG=1.
3. Hold INSTR_VALID high continuously -> INSTR_READY low for 2 cycles after each accept; accepts every 3 cycles; exactly one DONE per instruction.
4. EXT_WE to r2=8'hAA during WAIT -> ignored, r2 takes the writeback value. EXT_WE in the accept cycle -> the instruction sees the old value and the external write lands.
5. wb_en=0 with r0+r1 overflowing -> all registers unchanged, CARRY_FLAG=1, DONE pulses.
6. Assert RESET low during WAIT -> all outputs 0, no DONE, no writeback. After release, INSTR_READY=1 and a new instruction completes normally.
7. Repeat tests 1 and 3 with ALU_LATENCY=0 and 3 -> DONE at accept+1 and accept+4.
